mem_port_arbiter: RTL and testbench

//  Shares the single-port unified Memory between the instruction-fetch (IF) and data-memory (DM) pipeline stages.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 57 +++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline IF/DM request ports plus unified Memory port bundle
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDRESS_SIZE = 32
);
  logic if_req;
  logic [ADDRESS_SIZE-1:0] if_addr;
  logic if_gnt;
  logic if_rvalid;
  logic [WORD_SIZE-1:0] if_rdata;
  logic dm_req;
  logic dm_we;
  logic [ADDRESS_SIZE-1:0] dm_addr;
  logic [WORD_SIZE-1:0] dm_wdata;
  logic dm_gnt;
  logic dm_rvalid;
  logic [WORD_SIZE-1:0] dm_rdata;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic mem_read;
  logic mem_write;
  logic [WORD_SIZE-1:0] mem_rdata;
  modport slave (
    input if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port Memory between IF and DM, DM priority with IF anti-starvation
module mem_port_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int ADDRESS_SIZE = 32,
  parameter int MAX_WAIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, next;
  logic cmd_we, cmd_if, if_win, dm_win;
  logic [3:0] wait_cnt;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q, if_rdata_q, dm_rdata_q;
  always_comb begin
    if_win = state != ISSUE && bus.if_req && (!bus.dm_req || wait_cnt == 4'(MAX_WAIT));
    dm_win = state != ISSUE && bus.dm_req && !if_win;
    next = state == ISSUE ? (cmd_we ? IDLE : RESP) : (if_win || dm_win ? ISSUE : IDLE);
    bus.mem_addr = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_read = state == ISSUE && !cmd_we;
    bus.mem_write = state == ISSUE && cmd_we;
    bus.if_gnt = state == ISSUE && cmd_if;
    bus.dm_gnt = state == ISSUE && !cmd_if;
    bus.if_rvalid = state == RESP && cmd_if;
    bus.dm_rvalid = state == RESP && !cmd_if;
    // Memory registers the word at the end of ISSUE, so it is forwarded in RESP and held afterwards
    bus.if_rdata = bus.if_rvalid ? bus.mem_rdata : if_rdata_q;
    bus.dm_rdata = bus.dm_rvalid ? bus.mem_rdata : dm_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wait_cnt <= '0;
      cmd_we <= 1'b0;
      cmd_if <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= next;
      if (if_win || dm_win) begin
        addr_q <= if_win ? bus.if_addr : bus.dm_addr;
        wdata_q <= if_win ? wdata_q : bus.dm_wdata;
        cmd_we <= dm_win && bus.dm_we;
        cmd_if <= if_win;
      end
      wait_cnt <= if_win ? 4'd0 :
                  (dm_win && bus.if_req && wait_cnt != 4'(MAX_WAIT)) ? wait_cnt + 4'd1 : wait_cnt;
      if (bus.if_rvalid) if_rdata_q <= bus.mem_rdata;
      if (bus.dm_rvalid) dm_rdata_q <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a queue-based scoreboard checking grants and read data
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  localparam logic [3:0] IG = 4'b1000, DG = 4'b0100, IR = 4'b0010, DR = 4'b0001;
  typedef struct {
    logic [3:0] ev;
    int c;
    logic we;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // Memory model: synchronous write, registered read, preloaded on the first edge
  logic [31:0] mem [0:4095];
  logic [31:0] rdq = '0;
  logic loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      mem[1000] <= 32'hDEADBEEF;
      mem[1001] <= 32'hCAFE0001;
      mem[1002] <= 32'hCAFE0002;
      for (int i = 1; i < 5; i++) mem[2000 + i] <= 32'hA0000000 + 32'(i);
      loaded <= 1'b1;
    end else begin
      if (bus.mem_write) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
      if (bus.mem_read) rdq <= mem[bus.mem_addr[11:0]];
    end
  end
  assign bus.mem_rdata = rdq;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [3:0] ev, input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
    q.push_back('{ev, c, we, a, d});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : monitor
    logic [3:0] ev;
    exp_t e;
    if (rst_n) begin
      ev = {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid};
      if (bus.mem_read && bus.mem_write) begin
        checks++;
        errors++;
        $display("FAIL rw_exclusive: mem_read and mem_write both 1 at cycle %0d", cyc);
      end
      if (ev != 4'b0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %b expected none (cycle %0d)", ev, cyc);
        end else begin
          e = q.pop_front();
          chk("event", 64'(ev), 64'(e.ev));
          chk("event_cycle", 64'(cyc), 64'(e.c));
          if (e.ev == IG || e.ev == DG) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(e.a));
            chk("mem_rd_wr", 64'({bus.mem_read, bus.mem_write}), 64'({~e.we, e.we}));
            if (e.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(e.d));
          end else chk("rdata", 64'(e.ev == IR ? bus.if_rdata : bus.dm_rdata), 64'(e.d));
        end
      end
    end
  end
  task automatic wait_gnt(input bit is_if);
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!(is_if ? bus.if_gnt : bus.dm_gnt) && t < 40);
    if (!(is_if ? bus.if_gnt : bus.dm_gnt)) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: %s got no grant expected one within 40 cycles", is_if ? "if" : "dm");
    end
  endtask
  task automatic if_reads(input logic [31:0] a0, input int n);
    for (int k = 0; k < n; k++) begin
      bus.if_req = 1'b1;
      bus.if_addr = a0 + 32'(k);
      wait_gnt(1'b1);
    end
    tick(1);
    bus.if_req = 1'b0;
  endtask
  task automatic dm_ops(input logic we, input logic [31:0] a0, input logic [31:0] d0, input int n);
    for (int k = 0; k < n; k++) begin
      bus.dm_req = 1'b1;
      bus.dm_we = we;
      bus.dm_addr = a0 + 32'(k);
      bus.dm_wdata = d0 + 32'(k);
      wait_gnt(1'b0);
    end
    tick(1);
    bus.dm_req = 1'b0;
  endtask
  task automatic outputs_zero(input string n);
    chk({n, "_ctrl"}, 64'({bus.if_gnt, bus.if_rvalid, bus.dm_gnt, bus.dm_rvalid, bus.mem_read, bus.mem_write}), 64'd0);
    chk({n, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({n, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({n, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
    chk({n, "_dm_rdata"}, 64'(bus.dm_rdata), 64'd0);
    chk({n, "_wait_cnt"}, 64'(dut.wait_cnt), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int b;
    int t;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    tick(2);
    outputs_zero("reset");
    rst_n = 1'b1;
    tick(1);
    // IF read alone
    b = cyc;
    push(IG, b + 1, 1'b0, 32'd1000, 32'h0);
    push(IR, b + 2, 1'b0, 32'h0, 32'hDEADBEEF);
    if_reads(32'd1000, 1);
    tick(2);
    chk("if_rdata_hold", 64'(bus.if_rdata), 64'hDEADBEEF);
    // DM write then read back
    b = cyc;
    push(DG, b + 1, 1'b1, 32'd2000, 32'h12345678);
    dm_ops(1'b1, 32'd2000, 32'h12345678, 1);
    tick(1);
    b = cyc;
    push(DG, b + 1, 1'b0, 32'd2000, 32'h0);
    push(DR, b + 2, 1'b0, 32'h0, 32'h12345678);
    dm_ops(1'b0, 32'd2000, 32'h0, 1);
    tick(2);
    chk("dm_rdata_hold", 64'(bus.dm_rdata), 64'h12345678);
    // Async reset in the middle of a DM write ISSUE cycle
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b1;
    bus.dm_addr = 32'd3000;
    bus.dm_wdata = 32'h55AA55AA;
    tick(1);
    chk("issue_before_reset", 64'({bus.mem_write, bus.dm_gnt}), 64'b11);
    #1;
    rst_n = 1'b0;
    bus.dm_req = 1'b0;
    #1;
    outputs_zero("mid_issue_reset");
    tick(1);
    chk("aborted_write", 64'(mem[3000]), 64'd0);
    rst_n = 1'b1;
    tick(1);
    // Contention: DM first, IF once DM drops
    b = cyc;
    push(DG, b + 1, 1'b0, 32'd2000, 32'h0);
    push(DR, b + 2, 1'b0, 32'h0, 32'h12345678);
    push(IG, b + 3, 1'b0, 32'd1001, 32'h0);
    push(IR, b + 4, 1'b0, 32'h0, 32'hCAFE0001);
    fork
      if_reads(32'd1001, 1);
      dm_ops(1'b0, 32'd2000, 32'h0, 1);
    join
    tick(2);
    // Starvation: DM wins MAX_WAIT arbitrations, then IF overrides
    b = cyc;
    for (int k = 0; k < 4; k++) begin
      push(DG, b + 1 + 2 * k, 1'b0, 32'd2000 + 32'(k), 32'h0);
      push(DR, b + 2 + 2 * k, 1'b0, 32'h0, k == 0 ? 32'h12345678 : 32'hA0000000 + 32'(k));
    end
    push(IG, b + 9, 1'b0, 32'd1002, 32'h0);
    push(IR, b + 10, 1'b0, 32'h0, 32'hCAFE0002);
    push(DG, b + 11, 1'b0, 32'd2004, 32'h0);
    push(DR, b + 12, 1'b0, 32'h0, 32'hA0000004);
    fork
      if_reads(32'd1002, 1);
      dm_ops(1'b0, 32'd2000, 32'h0, 5);
      begin
        tick(8);
        chk("wait_cnt_saturated", 64'(dut.wait_cnt), 64'd4);
        tick(2);
        chk("wait_cnt_cleared", 64'(dut.wait_cnt), 64'd0);
      end
    join
    tick(2);
    // Back-to-back IF reads
    b = cyc;
    for (int k = 0; k < 3; k++) begin
      push(IG, b + 1 + 2 * k, 1'b0, 32'd1000 + 32'(k), 32'h0);
      push(IR, b + 2 + 2 * k, 1'b0, 32'h0, k == 0 ? 32'hDEADBEEF : 32'hCAFE0000 + 32'(k));
    end
    if_reads(32'd1000, 3);
    tick(3);
    t = 0;
    while (q.size() != 0 && t < 20) begin
      tick(1);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_events: got %0d outstanding expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
